ddd_load_ctrl: RTL and testbench

- Register-bank and sequencing stage directly upstream of the 3D3444 delay-chip programmer.
- Holds VME-written shadow delay and output-enable values and copies them to active outputs on commit.
- Drives the programmer's start/busy handshake and checks its verify result.
- Retries failed loads and reports done, error and retry status to VME.

---
 rtl/ddd_load_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ddd_load_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddd_load_ctrl.sv
// Shadow/active delay register bank and load sequencer in front of the 3D3444 programmer.
// A commit copies shadow to active once, then runs start/busy/verify with bounded retries.
module ddd_load_ctrl #(
    parameter int MAX_RETRY    = 3,
    parameter int ACK_TIMEOUT  = 255,
    parameter int DONE_TIMEOUT = 1023
) (
    input  logic        clock,
    input  logic        global_reset_n,
    input  logic        wr_en,
    input  logic [1:0]  wr_adr,
    input  logic [15:0] wr_data,
    input  logic        commit,
    output logic [3:0]  delay_ch0,
    output logic [3:0]  delay_ch1,
    output logic [3:0]  delay_ch2,
    output logic [3:0]  delay_ch3,
    output logic [3:0]  delay_ch4,
    output logic [3:0]  delay_ch5,
    output logic [3:0]  delay_ch6,
    output logic [3:0]  delay_ch7,
    output logic [3:0]  delay_ch8,
    output logic [3:0]  delay_ch9,
    output logic [3:0]  delay_ch10,
    output logic [3:0]  delay_ch11,
    output logic [11:0] oe,
    output logic        ddd_start,
    input  logic        ddd_busy,
    input  logic        ddd_verify_ok,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_error,
    output logic        timeout_err,
    output logic [1:0]  retry_cnt,
    output logic [2:0]  fsm_state
);

    // Programmer handshake: ddd_start is a level held until ddd_busy is seen high,
    // then dropped; the programmer finishes only after start is low, and
    // ddd_verify_ok is valid from the cycle ddd_busy falls.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_ASSERT,
        S_DROP,
        S_WAIT_DONE,
        S_CHECK,
        S_REARM,
        S_FAIL_TO
    } state_t;

    localparam logic [9:0] ACK_LIM   = 10'(ACK_TIMEOUT);
    localparam logic [9:0] DONE_LIM  = 10'(DONE_TIMEOUT);
    localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY);

    state_t      state, state_nx;
    logic [9:0]  cnt, cnt_nx, cnt_inc;
    logic [1:0]  retry_nx;
    logic        done_nx, err_nx, to_nx;
    logic        pending, pending_nx;
    logic        copy_active, clr_pending;

    logic [47:0] shadow_dly, active_dly;
    logic [11:0] shadow_oe, active_oe;

    assign cnt_inc    = (cnt == 10'h3FF) ? cnt : cnt + 10'd1;
    assign pending_nx = commit | (pending & ~clr_pending);
    assign fsm_state  = state;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        retry_nx    = retry_cnt;
        done_nx     = load_done;
        err_nx      = load_error;
        to_nx       = timeout_err;
        copy_active = 1'b0;
        clr_pending = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending) state_nx = S_ARM;
            end
            S_ARM: begin
                copy_active = 1'b1;
                clr_pending = 1'b1;
                done_nx     = 1'b0;
                err_nx      = 1'b0;
                to_nx       = 1'b0;
                retry_nx    = 2'd0;
                cnt_nx      = 10'd0;
                state_nx    = S_ASSERT;
            end
            S_REARM: begin
                cnt_nx   = 10'd0;
                state_nx = S_ASSERT;
            end
            S_ASSERT: begin
                cnt_nx = cnt_inc;
                if (ddd_busy)                state_nx = S_DROP;
                else if (cnt_inc == ACK_LIM) state_nx = S_FAIL_TO;
            end
            S_DROP: begin
                cnt_nx   = 10'd0;
                state_nx = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                cnt_nx = cnt_inc;
                if (!ddd_busy)                state_nx = S_CHECK;
                else if (cnt_inc == DONE_LIM) state_nx = S_FAIL_TO;
            end
            S_CHECK: begin
                if (ddd_verify_ok) begin
                    done_nx  = 1'b1;
                    state_nx = S_IDLE;
                end else if (retry_cnt < RETRY_LIM) begin
                    retry_nx = retry_cnt + 2'd1;
                    state_nx = S_REARM;
                end else begin
                    err_nx   = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_FAIL_TO: begin
                err_nx   = 1'b1;
                to_nx    = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ddd_start and load_busy are registered from next-state so they track the FSM exactly.
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state       <= S_IDLE;
            cnt         <= 10'd0;
            retry_cnt   <= 2'd0;
            load_done   <= 1'b0;
            load_error  <= 1'b0;
            timeout_err <= 1'b0;
            pending     <= 1'b0;
            ddd_start   <= 1'b0;
            load_busy   <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            retry_cnt   <= retry_nx;
            load_done   <= done_nx;
            load_error  <= err_nx;
            timeout_err <= to_nx;
            pending     <= pending_nx;
            ddd_start   <= (state_nx == S_ASSERT);
            load_busy   <= (state_nx != S_IDLE) | pending_nx;
        end
    end

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            shadow_dly <= 48'd0;
            shadow_oe  <= 12'hFFF;
            active_dly <= 48'd0;
            active_oe  <= 12'hFFF;
        end else begin
            if (wr_en) begin
                case (wr_adr)
                    2'd0:    shadow_dly[15:0]  <= wr_data;
                    2'd1:    shadow_dly[31:16] <= wr_data;
                    2'd2:    shadow_dly[47:32] <= wr_data;
                    default: shadow_oe         <= wr_data[11:0];
                endcase
            end
            if (copy_active) begin
                active_dly <= shadow_dly;
                active_oe  <= shadow_oe;
            end
        end
    end

    assign delay_ch0  = active_dly[3:0];
    assign delay_ch1  = active_dly[7:4];
    assign delay_ch2  = active_dly[11:8];
    assign delay_ch3  = active_dly[15:12];
    assign delay_ch4  = active_dly[19:16];
    assign delay_ch5  = active_dly[23:20];
    assign delay_ch6  = active_dly[27:24];
    assign delay_ch7  = active_dly[31:28];
    assign delay_ch8  = active_dly[35:32];
    assign delay_ch9  = active_dly[39:36];
    assign delay_ch10 = active_dly[43:40];
    assign delay_ch11 = active_dly[47:44];
    assign oe         = active_oe;

endmodule

// File: tb/tb_ddd_load_ctrl.sv
// Bench for ddd_load_ctrl: a behavioural programmer drives busy/verify, a shadow model
// predicts each load's active values, pulse count/length and final status flags.
module tb_ddd_load_ctrl;
  localparam int MAX_RETRY    = 3;
  localparam int ACK_TIMEOUT  = 255;
  localparam int DONE_TIMEOUT = 1023;

  logic        clock, global_reset_n, wr_en, commit, ddd_busy, ddd_verify_ok;
  logic [1:0]  wr_adr;
  logic [15:0] wr_data;
  logic [3:0]  delay_ch0, delay_ch1, delay_ch2, delay_ch3, delay_ch4, delay_ch5;
  logic [3:0]  delay_ch6, delay_ch7, delay_ch8, delay_ch9, delay_ch10, delay_ch11;
  logic [11:0] oe;
  logic        ddd_start, load_busy, load_done, load_error, timeout_err;
  logic [1:0]  retry_cnt;
  logic [2:0]  fsm_state;
  logic [47:0] dut_dly;

  assign dut_dly = {delay_ch11, delay_ch10, delay_ch9, delay_ch8, delay_ch7, delay_ch6,
                    delay_ch5, delay_ch4, delay_ch3, delay_ch2, delay_ch1, delay_ch0};

  ddd_load_ctrl #(.MAX_RETRY(MAX_RETRY), .ACK_TIMEOUT(ACK_TIMEOUT), .DONE_TIMEOUT(DONE_TIMEOUT)) dut (
    .clock(clock), .global_reset_n(global_reset_n), .wr_en(wr_en), .wr_adr(wr_adr),
    .wr_data(wr_data), .commit(commit),
    .delay_ch0(delay_ch0), .delay_ch1(delay_ch1), .delay_ch2(delay_ch2), .delay_ch3(delay_ch3),
    .delay_ch4(delay_ch4), .delay_ch5(delay_ch5), .delay_ch6(delay_ch6), .delay_ch7(delay_ch7),
    .delay_ch8(delay_ch8), .delay_ch9(delay_ch9), .delay_ch10(delay_ch10), .delay_ch11(delay_ch11),
    .oe(oe), .ddd_start(ddd_start), .ddd_busy(ddd_busy), .ddd_verify_ok(ddd_verify_ok),
    .load_busy(load_busy), .load_done(load_done), .load_error(load_error),
    .timeout_err(timeout_err), .retry_cnt(retry_cnt), .fsm_state(fsm_state)
  );

  int          total, bad;
  logic [59:0] exp_q[$];     // {oe, delays} each pending load must present
  int          len_q[$];     // observed ddd_start pulse lengths
  logic        ok_q[$];      // verify results the programmer returns, per attempt
  int          ack_delay, busy_len;
  bit          never_ack, act_chk_en;
  logic [3:0]  sh_nib [12];
  logic [11:0] sh_oe;

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // shadow model
  task automatic model_reset();
    for (int i = 0; i < 12; i++) sh_nib[i] = 4'h0;
    sh_oe = 12'hFFF;
  endtask

  task automatic model_write(input logic [1:0] a, input logic [15:0] d);
    if (a == 2'd3) sh_oe = d[11:0];
    else for (int i = 0; i < 4; i++) sh_nib[int'(a) * 4 + i] = d[i*4 +: 4];
  endtask

  function automatic logic [59:0] snap_sh();
    logic [47:0] v;
    for (int i = 0; i < 12; i++) v[i*4 +: 4] = sh_nib[i];
    return {sh_oe, v};
  endfunction

  // programmer model: answers each start level with busy, returns queued verify results
  initial begin : programmer
    ddd_busy = 1'b0;
    ddd_verify_ok = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (ddd_start && !never_ack) begin
        for (int i = 1; i < ack_delay; i++) begin @(posedge clock); #1; end
        ddd_busy = 1'b1;
        while (ddd_start) begin @(posedge clock); #1; end
        for (int i = 0; i < busy_len; i++) begin @(posedge clock); #1; end
        ddd_verify_ok = (ok_q.size() > 0) ? ok_q.pop_front() : 1'b1;
        ddd_busy = 1'b0;
      end
    end
  end

  // per-cycle compare: active values must match the in-flight load whenever the chips are being driven
  initial begin : monitor
    int   cur_len;
    logic prev_start, prev_fin, fin;
    cur_len = 0; prev_start = 1'b0; prev_fin = 1'b0;
    forever begin
      @(negedge clock);
      if (ddd_start) cur_len++;
      else if (prev_start) begin
        len_q.push_back(cur_len);
        cur_len = 0;
      end
      prev_start = ddd_start;
      fin = load_done | load_error;
      if (act_chk_en && (ddd_start || ddd_busy) && exp_q.size() > 0) begin
        chk("active_dly", {16'h0, dut_dly}, {16'h0, exp_q[0][47:0]});
        chk("active_oe", {52'h0, oe}, {52'h0, exp_q[0][59:48]});
      end
      if (fin && !prev_fin && exp_q.size() > 0) void'(exp_q.pop_front());
      prev_fin = fin;
    end
  end

  // driver tasks
  task automatic write_reg(input logic [1:0] a, input logic [15:0] d);
    @(posedge clock); #1;
    wr_en = 1'b1; wr_adr = a; wr_data = d;
    @(posedge clock); #1;
    wr_en = 1'b0;
    model_write(a, d);
  endtask

  task automatic commit_pulse(input bit w, input logic [1:0] a, input logic [15:0] d);
    @(posedge clock); #1;
    commit = 1'b1;
    if (w) begin wr_en = 1'b1; wr_adr = a; wr_data = d; end
    @(posedge clock); #1;
    commit = 1'b0; wr_en = 1'b0;
    @(negedge clock); @(negedge clock);
    chk("busy_after_commit", load_busy, 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (load_busy && n < 6000) begin @(negedge clock); n++; end
    chk({name, "_idle_wait"}, n < 6000, 1);
    @(negedge clock);
  endtask

  task automatic run_load(input logic [3:0] ok_seq, input int ackd, input int blen,
                          input bit w, input logic [1:0] a, input logic [15:0] d, input string name);
    logic [59:0] snap;
    int first_ok, exp_pulses, nbad;
    ok_q.delete();
    for (int i = 0; i <= MAX_RETRY; i++) ok_q.push_back(ok_seq[i]);
    ack_delay = ackd; busy_len = blen; never_ack = 1'b0; act_chk_en = 1'b1;
    if (w) model_write(a, d);
    snap = snap_sh();
    exp_q.push_back(snap);
    len_q.delete();
    commit_pulse(w, a, d);
    wait_idle(name);
    first_ok = -1;
    for (int i = 0; i <= MAX_RETRY; i++) if (first_ok < 0 && ok_seq[i]) first_ok = i;
    exp_pulses = (first_ok < 0) ? MAX_RETRY + 1 : first_ok + 1;
    chk({name, "_pulses"}, len_q.size(), exp_pulses);
    nbad = 0;
    foreach (len_q[i]) if (len_q[i] != ackd) nbad++;
    chk({name, "_pulse_len_bad"}, nbad, 0);
    chk({name, "_done"}, load_done, first_ok >= 0);
    chk({name, "_error"}, load_error, first_ok < 0);
    chk({name, "_timeout"}, timeout_err, 0);
    chk({name, "_retry"}, retry_cnt, (first_ok < 0) ? MAX_RETRY : first_ok);
    chk({name, "_dly"}, dut_dly, snap[47:0]);
    chk({name, "_oe"}, oe, snap[59:48]);
    chk({name, "_exp_drained"}, exp_q.size(), 0);
    ok_q.delete();
  endtask

  initial begin : main
    int n;
    int nw;
    logic [15:0] old47;
    total = 0; bad = 0;
    global_reset_n = 1'b0; wr_en = 1'b0; wr_adr = 2'd0; wr_data = 16'h0; commit = 1'b0;
    never_ack = 1'b0; ack_delay = 3; busy_len = 2; act_chk_en = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_start", ddd_start, 0);
    chk("rst_load_busy", load_busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_error", load_error, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_retry", retry_cnt, 0);
    chk("rst_dly", dut_dly, 0);
    chk("rst_oe", oe, 12'hFFF);
    @(posedge clock); #1;
    global_reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // basic load, busy answers 3 clocks after start
    write_reg(2'd0, 16'h4321);
    write_reg(2'd3, 16'h00F0);
    run_load(4'b0001, 3, 2, 1'b0, 2'd0, 16'h0, "basic");
    chk("basic_ch0", delay_ch0, 4'h1);
    chk("basic_ch3", delay_ch3, 4'h4);
    chk("basic_oe_lit", oe, 12'h0F0);
    chk("basic_len_lit", (len_q.size() > 0) ? len_q[0] : 0, 3);

    // two verify failures then success
    run_load(4'b0100, 2, 3, 1'b0, 2'd0, 16'h0, "retry2");
    chk("retry2_retry_lit", retry_cnt, 2);
    chk("retry2_pulses_lit", len_q.size(), 3);

    // verify never succeeds
    run_load(4'b0000, 2, 1, 1'b0, 2'd0, 16'h0, "exhaust");
    chk("exhaust_pulses_lit", len_q.size(), 4);
    chk("exhaust_retry_lit", retry_cnt, 3);
    chk("exhaust_err_lit", load_error, 1);

    // busy never rises
    ok_q.delete(); never_ack = 1'b1; act_chk_en = 1'b1;
    exp_q.push_back(snap_sh()); len_q.delete();
    commit_pulse(1'b0, 2'd0, 16'h0);
    wait_idle("ack_to");
    chk("ack_to_pulses", len_q.size(), 1);
    chk("ack_to_len", (len_q.size() > 0) ? len_q[0] : 0, ACK_TIMEOUT);
    chk("ack_to_error", load_error, 1);
    chk("ack_to_timeout", timeout_err, 1);
    chk("ack_to_done", load_done, 0);
    chk("ack_to_retry", retry_cnt, 0);
    chk("ack_to_start", ddd_start, 0);
    never_ack = 1'b0;

    // busy never falls in time
    ack_delay = 2; busy_len = 1100;
    exp_q.push_back(snap_sh()); len_q.delete();
    commit_pulse(1'b0, 2'd0, 16'h0);
    wait_idle("done_to");
    chk("done_to_pulses", len_q.size(), 1);
    chk("done_to_error", load_error, 1);
    chk("done_to_timeout", timeout_err, 1);
    chk("done_to_done", load_done, 0);
    n = 0;
    while (ddd_busy && n < 2000) begin @(negedge clock); n++; end
    chk("done_to_busy_release", n < 2000, 1);

    // commit while a load is in flight, with a shadow write in between
    write_reg(2'd1, 16'h5555);
    ok_q.delete(); ack_delay = 4; busy_len = 14; act_chk_en = 1'b1;
    old47 = {sh_nib[7], sh_nib[6], sh_nib[5], sh_nib[4]};
    exp_q.push_back(snap_sh()); len_q.delete();
    commit_pulse(1'b0, 2'd0, 16'h0);
    n = 0;
    while (!ddd_busy && n < 100) begin @(negedge clock); n++; end
    chk("queued_wait_busy", n < 100, 1);
    write_reg(2'd1, 16'hAAAA);
    exp_q.push_back(snap_sh());
    commit_pulse(1'b0, 2'd0, 16'h0);
    n = 0;
    while (!load_done && n < 500) begin @(negedge clock); n++; end
    chk("queued_wait_done1", n < 500, 1);
    chk("queued_ch47_held", {delay_ch7, delay_ch6, delay_ch5, delay_ch4}, old47);
    chk("queued_still_busy", load_busy, 1);
    wait_idle("queued");
    chk("queued_pulses", len_q.size(), 2);
    chk("queued_ch47_new", {delay_ch7, delay_ch6, delay_ch5, delay_ch4}, 16'hAAAA);
    chk("queued_done", load_done, 1);
    chk("queued_exp_drained", exp_q.size(), 0);

    // write and commit in the same cycle
    run_load(4'b0001, 2, 1, 1'b1, 2'd2, 16'hBEEF, "wrcommit");
    chk("wrcommit_ch8_11", {delay_ch11, delay_ch10, delay_ch9, delay_ch8}, 16'hBEEF);

    // randomized loads
    for (int it = 0; it < 12; it++) begin
      nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) write_reg(2'($urandom_range(0, 3)), 16'($urandom));
      run_load(4'($urandom_range(0, 15)), $urandom_range(1, 6), $urandom_range(0, 5),
               1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom), "rand");
    end

    // reset during wait_done
    write_reg(2'd3, 16'h0123);
    ok_q.delete(); ack_delay = 2; busy_len = 40; act_chk_en = 1'b1;
    exp_q.push_back(snap_sh()); len_q.delete();
    commit_pulse(1'b0, 2'd0, 16'h0);
    n = 0;
    while (!(ddd_busy && !ddd_start) && n < 100) begin @(negedge clock); n++; end
    chk("rstw_wait", n < 100, 1);
    repeat (3) @(negedge clock);
    chk("rstw_oe_before", oe, 12'h123);
    act_chk_en = 1'b0;
    global_reset_n = 1'b0;
    #1;
    chk("rstw_start", ddd_start, 0);
    chk("rstw_oe", oe, 12'hFFF);
    chk("rstw_dly", dut_dly, 0);
    chk("rstw_load_busy", load_busy, 0);
    exp_q.delete();
    model_reset();
    @(posedge clock); @(posedge clock); #1;
    global_reset_n = 1'b1;
    len_q.delete();
    repeat (30) @(negedge clock);
    chk("rstw_idle_busy", load_busy, 0);
    chk("rstw_no_start", len_q.size(), 0);
    chk("rstw_start_low", ddd_start, 0);
    chk("rstw_done", load_done, 0);
    n = 0;
    while (ddd_busy && n < 100) begin @(negedge clock); n++; end
    chk("rstw_busy_release", n < 100, 1);

    // reset while start is asserted
    never_ack = 1'b1; len_q.delete();
    commit_pulse(1'b0, 2'd0, 16'h0);
    n = 0;
    while (!ddd_start && n < 20) begin @(negedge clock); n++; end
    chk("rsta_wait_start", n < 20, 1);
    #2;
    global_reset_n = 1'b0;
    #1;
    chk("rsta_start_async", ddd_start, 0);
    chk("rsta_load_busy", load_busy, 0);
    @(posedge clock); #1;
    global_reset_n = 1'b1;
    never_ack = 1'b0;
    repeat (5) @(negedge clock);
    len_q.delete(); exp_q.delete();

    // load after reset carries the reset shadow values
    run_load(4'b0001, 1, 0, 1'b0, 2'd0, 16'h0, "post_rst");
    chk("post_rst_oe_lit", oe, 12'hFFF);
    chk("post_rst_dly_lit", dut_dly, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
